// File: rtl/mult_shift_add_ctrl_if.sv
// rtl/mult_shift_add_ctrl_if.sv - request, result and external ALU signals of the shift-add multiplier
interface mult_shift_add_ctrl_if;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       alu_cout;
  logic [7:0] product;
  logic       busy;
  logic       done;

  // Requester side: issues operands, owns the external ALU, consumes the result
  modport master (
    output start, multiplicand, multiplier, alu_f, alu_cout,
    input  alu_a, alu_b, alu_s, alu_m, alu_cin, product, busy, done
  );

  // Controller side
  modport slave (
    input  start, multiplicand, multiplier, alu_f, alu_cout,
    output alu_a, alu_b, alu_s, alu_m, alu_cin, product, busy, done
  );
endinterface

// File: rtl/mult_shift_add_ctrl.sv
// rtl/mult_shift_add_ctrl.sv - 4x4 unsigned shift-add multiplier controller driving an external 74181 ALU
module mult_shift_add_ctrl (
  input logic                 clk,
  input logic                 rst,
  mult_shift_add_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] mcand;
  logic [3:0] acc;
  logic [3:0] q;
  logic       c;
  logic [2:0] cnt;
  logic [7:0] product;

  // Sequencer: one TEST/ADD/SHIFT pass per multiplier bit, LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= 4'd0;
      acc     <= 4'd0;
      q       <= 4'd0;
      c       <= 1'b0;
      cnt     <= 3'd0;
      product <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.multiplicand;
            q     <= bus.multiplier;
            acc   <= 4'd0;
            c     <= 1'b0;
            cnt   <= 3'd0;
            state <= TEST;
          end
        end
        TEST: begin
          state <= q[0] ? ADD : SHIFT;
        end
        ADD: begin
          // ALU is set up for A plus B this cycle; its carry-out becomes bit 4
          {c, acc} <= {bus.alu_cout, bus.alu_f};
          state    <= SHIFT;
        end
        SHIFT: begin
          {c, acc, q} <= {1'b0, c, acc, q[3:1]};
          cnt         <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            // Fourth shift completes the product; capture the post-shift {acc,q}
            product <= {c, acc, q[3:1]};
            state   <= DONE;
          end else begin
            state <= TEST;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode: ALU adds only in ADD, otherwise passes A through
  always_comb begin
    bus.alu_a   = acc;
    bus.alu_b   = mcand;
    bus.alu_cin = 1'b0;
    if (state == ADD) begin
      bus.alu_s = 4'b1001;
      bus.alu_m = 1'b0;
    end else begin
      bus.alu_s = 4'b1111;
      bus.alu_m = 1'b1;
    end
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.product = product;
  end

endmodule
